// File: rtl/mult_sequencer.sv
// Operand sequencer in front of the parallel multiplier: buffers signed operand
// pairs, launches one product at a time and returns results on a valid/ready port.
module mult_sequencer #(
    parameter int tamano  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [tamano-1:0]       IN_A,
    input  logic [tamano-1:0]       IN_B,
    output logic [tamano-1:0]       MULT_A,
    output logic [tamano-1:0]       MULT_B,
    output logic                    MULT_START,
    input  logic                    MULT_END,
    input  logic [2*tamano-1:0]     MULT_S,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [2*tamano-1:0]     OUT_S,
    output logic                    OUT_ERR,
    output logic [$clog2(DEPTH):0]  COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = 2 * tamano;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [TW-1:0] timer;

    logic push;
    logic pop;
    logic capture;
    logic abort;
    logic nonempty;
    logic tmo;

    assign nonempty = COUNT != '0;
    assign IN_READY = COUNT < CW'(DEPTH);
    assign push     = IN_VALID && IN_READY;
    // Timer holds the WAIT cycles already spent; abort on the last allowed one.
    assign tmo      = timer == TW'(TIMEOUT - 2);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (nonempty) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (MULT_END || tmo) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (OUT_READY) state_nxt = nonempty ? S_LAUNCH : S_IDLE;
            end
        endcase
    end

    always_comb begin
        MULT_START = 1'b0;
        OUT_VALID  = 1'b0;
        pop        = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        unique case (state)
            S_IDLE: begin
                pop = nonempty;
            end
            S_LAUNCH: begin
                MULT_START = 1'b1;
            end
            S_WAIT: begin
                capture = MULT_END;
                abort   = !MULT_END && tmo;
            end
            S_DONE: begin
                OUT_VALID = 1'b1;
                pop       = OUT_READY && nonempty;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (push) mem[wr_ptr] <= {IN_A, IN_B};
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            COUNT   <= '0;
            MULT_A  <= '0;
            MULT_B  <= '0;
            timer   <= '0;
            OUT_S   <= '0;
            OUT_ERR <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                {MULT_A, MULT_B} <= mem[rd_ptr];
            end
            if (push && !pop) begin
                COUNT <= COUNT + CW'(1);
            end else if (pop && !push) begin
                COUNT <= COUNT - CW'(1);
            end
            if (state == S_LAUNCH) begin
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + TW'(1);
            end
            if (capture) begin
                OUT_S   <= MULT_S;
                OUT_ERR <= 1'b0;
            end else if (abort) begin
                OUT_S   <= '0;
                OUT_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: behavioural multiplier with adjustable latency,
// in-order product scoreboard and directed scenarios plus random batches.
module tb_mult_sequencer;

    localparam int TAM = 8;
    localparam int DEP = 4;
    localparam int TMO = 16;
    localparam int CW  = $clog2(DEP) + 1;

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b1;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [TAM-1:0]   IN_A = '0;
    logic [TAM-1:0]   IN_B = '0;
    logic [TAM-1:0]   MULT_A;
    logic [TAM-1:0]   MULT_B;
    logic             MULT_START;
    logic             MULT_END = 1'b0;
    logic [2*TAM-1:0] MULT_S = '0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [2*TAM-1:0] OUT_S;
    logic             OUT_ERR;
    logic [CW-1:0]    COUNT;

    mult_sequencer #(.tamano(TAM), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_A(IN_A), .IN_B(IN_B),
        .MULT_A(MULT_A), .MULT_B(MULT_B),
        .MULT_START(MULT_START), .MULT_END(MULT_END), .MULT_S(MULT_S),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_S(OUT_S), .OUT_ERR(OUT_ERR), .COUNT(COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic signed [TAM-1:0] a;
        logic signed [TAM-1:0] b;
        bit                    err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   push_cyc = 0;
    int   mlat = 4;
    bit   dead = 0;
    bit   stray = 0;
    bit   auto_rdy = 0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multiplier model: END one cycle per op, mlat cycles after START.
    logic signed [TAM-1:0] m_a, m_b;
    bit m_act = 0;
    int m_cnt = 0;
    int mp;
    always @(negedge CLOCK) begin
        MULT_END = 1'b0;
        MULT_S   = 16'($urandom);
        if (RESET) begin
            m_act = 0;
        end else if (MULT_START) begin
            chk("start_busy", m_act, 0);
            m_act = 1; m_cnt = 0;
            m_a = MULT_A; m_b = MULT_B;
            if (stray) MULT_END = ($urandom_range(0, 1) == 1);
        end else if (m_act) begin
            m_cnt++;
            if (m_cnt == mlat) begin
                m_act = 0;
                if (!dead) begin
                    mp = int'(m_a) * int'(m_b);
                    MULT_END = 1'b1;
                    MULT_S = mp[15:0];
                end
            end
        end else if (stray && !dead) begin
            MULT_END = ($urandom_range(0, 3) == 0);
        end
    end

    // Scoreboard and protocol monitor
    bit rst_d = 1, prev_ov = 0, prev_rdy = 0, prev_start = 0, op_live = 0;
    logic [15:0] prev_s;
    logic prev_err;
    logic [TAM-1:0] cap_a, cap_b;
    exp_t e;
    int rp;
    logic [15:0] exp_s;
    always @(negedge CLOCK) begin
        if (RESET) begin
            exp_q.delete();
            rst_d = 1; prev_ov = 0; prev_start = 0; op_live = 0;
        end else begin
            if (rst_d) chk("start_after_rst", MULT_START, 0);
            rst_d = 0;
            chk("count_max", COUNT <= DEP, 1);
            chk("in_ready", IN_READY, COUNT < DEP);
            if (MULT_START) begin
                chk("start_pulse", prev_start, 0);
                cap_a = MULT_A; cap_b = MULT_B; op_live = 1;
            end else if (op_live) begin
                chk("hold_a", MULT_A, cap_a);
                chk("hold_b", MULT_B, cap_b);
            end
            if (prev_ov && !prev_rdy) begin
                chk("hold_valid", OUT_VALID, 1);
                chk("hold_s", OUT_S, prev_s);
                chk("hold_err", OUT_ERR, prev_err);
            end
            if (IN_VALID && IN_READY) begin
                e.a = IN_A; e.b = IN_B;
                e.err = dead || (mlat >= TMO);
                exp_q.push_back(e);
            end
            if (OUT_VALID && OUT_READY) begin
                chk("result_queued", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    rp = int'(e.a) * int'(e.b);
                    exp_s = e.err ? 16'h0 : rp[15:0];
                    chk("out_s", OUT_S, exp_s);
                    chk("out_err", OUT_ERR, e.err);
                end
                op_live = 0;
            end
            prev_ov = OUT_VALID; prev_rdy = OUT_READY;
            prev_s = OUT_S; prev_err = OUT_ERR; prev_start = MULT_START;
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        bit ok = 0;
        IN_VALID = 1'b1; IN_A = a; IN_B = b;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLOCK);
            if (IN_READY) begin
                ok = 1; push_cyc = cyc;
                break;
            end
            @(posedge CLOCK); #1;
            if (auto_rdy) OUT_READY = 1'b1;
        end
        chk("push_accept", ok, 1);
        @(posedge CLOCK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_start(output int c);
        bit ok = 0;
        c = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLOCK);
            if (MULT_START) begin ok = 1; c = cyc; break; end
        end
        chk("wait_start", ok, 1);
    endtask

    task automatic wait_valid(output int c);
        bit ok = 0;
        c = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLOCK);
            if (OUT_VALID) begin ok = 1; c = cyc; break; end
        end
        chk("wait_valid", ok, 1);
    endtask

    task automatic drain();
        bit ok = 0;
        OUT_READY = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLOCK);
            if (exp_q.size() == 0 && !OUT_VALID) begin ok = 1; break; end
        end
        chk("drain", ok, 1);
        @(posedge CLOCK); #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_mult_a", MULT_A, 0);
        chk("rst_mult_b", MULT_B, 0);
        chk("rst_out_s", OUT_S, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_start", MULT_START, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_err", OUT_ERR, 0);
    endtask

    int c0, c1;

    initial begin
        // reset state
        @(negedge CLOCK);
        check_reset_vals();
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        chk("ready_after_rst", IN_READY, 1);
        @(posedge CLOCK); #1;

        // single product with latency and hold checks
        push(8'd3, 8'hFB);
        wait_start(c0);
        chk("lat_start", c0 - push_cyc, 2);
        chk("start_a", MULT_A, 8'd3);
        chk("start_b", MULT_B, 8'hFB);
        wait_valid(c1);
        chk("lat_valid", c1 - push_cyc, 7);
        chk("single_s", OUT_S, 16'hFFF1);
        repeat (5) @(negedge CLOCK);
        chk("single_a_held", MULT_A, 8'd3);
        @(posedge CLOCK); #1;
        drain();

        // extremes back-to-back
        OUT_READY = 1'b1;
        push(8'h80, 8'h80);
        push(8'h7F, 8'h80);
        push(8'h00, 8'hFF);
        drain();

        // full FIFO with backpressure
        OUT_READY = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(i * 7), 8'(-i));
        IN_VALID = 1'b1; IN_A = 8'd100; IN_B = 8'd3;
        repeat (12) @(posedge CLOCK);
        #1;
        @(negedge CLOCK);
        chk("full_count", COUNT, DEP);
        chk("full_ready", IN_READY, 0);
        chk("full_valid", OUT_VALID, 1);
        @(posedge CLOCK); #1;
        OUT_READY = 1'b1;
        @(negedge CLOCK);
        chk("pop_ready_same", IN_READY, 0);
        @(negedge CLOCK);
        chk("pop_ready_rise", IN_READY, 1);
        chk("pop_count", COUNT, DEP - 1);
        @(posedge CLOCK); #1;
        IN_VALID = 1'b0;
        drain();

        // push and pop on the same edge keep COUNT
        OUT_READY = 1'b0;
        push(8'd5, 8'd6);
        push(8'd7, 8'd8);
        wait_valid(c1);
        @(posedge CLOCK); #1;
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; IN_A = 8'd9; IN_B = 8'd10;
        @(negedge CLOCK);
        chk("pp_count_before", COUNT, 1);
        @(posedge CLOCK); #1;
        IN_VALID = 1'b0;
        @(negedge CLOCK);
        chk("pp_count_after", COUNT, 1);
        @(posedge CLOCK); #1;
        drain();

        // timeout then recovery
        dead = 1;
        push(8'd2, 8'd2);
        wait_start(c0);
        wait_valid(c1);
        chk("tmo_lat", c1 - c0, TMO);
        chk("tmo_s", OUT_S, 0);
        chk("tmo_err", OUT_ERR, 1);
        @(posedge CLOCK); #1;
        drain();
        dead = 0;
        push(8'd11, 8'hF3);
        drain();
        chk("recover_err", OUT_ERR, 0);

        // random batches; first two hit both sides of the timeout edge
        stray = 1;
        auto_rdy = 1;
        for (int bt = 0; bt < 4; bt++) begin
            mlat = (bt == 0) ? TMO - 1 : (bt == 1) ? TMO : $urandom_range(1, TMO);
            for (int i = 0; i < 8; i++) begin
                OUT_READY = $urandom_range(0, 1) == 1;
                push(8'($urandom), 8'($urandom));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge CLOCK); #1;
                    OUT_READY = $urandom_range(0, 1) == 1;
                end
            end
            drain();
        end
        stray = 0;
        auto_rdy = 0;

        // reset in the middle of WAIT
        mlat = 8;
        OUT_READY = 1'b1;
        push(8'd12, 8'd12);
        push(8'd13, 8'd13);
        push(8'd14, 8'd14);
        wait_start(c0);
        repeat (3) @(negedge CLOCK);
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        @(negedge CLOCK);
        check_reset_vals();
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        chk("post_rst_ready", IN_READY, 1);
        chk("post_rst_count", COUNT, 0);
        repeat (20) @(negedge CLOCK);
        chk("post_rst_idle", OUT_VALID, 0);
        @(posedge CLOCK); #1;
        mlat = 4;
        push(8'hF9, 8'd9);
        wait_valid(c1);
        chk("post_rst_s", OUT_S, 16'hFFC1);
        @(posedge CLOCK); #1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
